// File: rtl/hella_cache_slave_mem.sv
// Single-outstanding hella-cache responder: byte-masked stores, size-extended loads,
// fixed-latency responses with optional periodic NACK injection.
module hella_cache_slave_mem #(
  parameter int NUM_ADDR_BITS  = 32,
  parameter int NUM_DATA_BITS  = 32,
  parameter int NUM_TAG_BITS   = 7,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RSP_LATENCY    = 2,
  parameter int NACK_PERIOD    = 0
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [NUM_ADDR_BITS-1:0]   req_addr_i,
  output logic                       req_ready_o,
  input  logic                       req_valid_i,
  input  logic [NUM_TAG_BITS-1:0]    req_tag_i,
  input  logic [4:0]                 req_cmd_i,
  input  logic [2:0]                 req_typ_i,
  input  logic [NUM_DATA_BITS-1:0]   req_data_i,
  input  logic [NUM_DATA_BITS/8-1:0] req_data_mask_i,
  input  logic                       req_kill_i,
  output logic                       rsp_valid_o,
  output logic                       rsp_nack_o,
  output logic [NUM_TAG_BITS-1:0]    rsp_tag_o,
  output logic [2:0]                 rsp_typ_o,
  output logic [NUM_DATA_BITS-1:0]   rsp_data_o
);
  localparam int NB    = NUM_DATA_BITS / 8;
  localparam int OB    = $clog2(NB);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int LW    = $clog2(RSP_LATENCY + 1);
  localparam int NW    = (NACK_PERIOD > 1) ? $clog2(NACK_PERIOD) : 1;
  localparam int NP1   = (NACK_PERIOD > 0) ? NACK_PERIOD - 1 : 0;

  typedef enum logic [1:0] {IDLE, CAPT, WAIT, RESP} state_t;

  state_t                     state_q, state_d;
  logic [MEM_DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic [OB-1:0]              off_q, off_d;
  logic [NUM_TAG_BITS-1:0]    tag_q, tag_d;
  logic [2:0]                 typ_q, typ_d;
  logic                       store_q, store_d;
  logic                       nack_q, nack_d;
  logic [NB-1:0]              mask_q, mask_d;
  logic [LW-1:0]              lat_q, lat_d;
  logic [NW-1:0]              ncnt_q, ncnt_d;
  logic [NUM_DATA_BITS-1:0]   rdata_q, rdata_d;
  logic [NUM_DATA_BITS-1:0]   mem_q [DEPTH];

  logic                       is_nack;
  logic                       wr_en;
  logic [NUM_DATA_BITS-1:0]   shifted;
  logic [NUM_DATA_BITS-1:0]   load_val;
  logic [OB-1:0]              lane_mask;
  logic [OB-1:0]              off_al;
  int                         sz;
  int                         nbits;

  generate
    if (NUM_ADDR_BITS > OB + MEM_DEPTH_LOG2) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^req_addr_i[NUM_ADDR_BITS-1:OB+MEM_DEPTH_LOG2];
    end
  endgenerate

  assign is_nack = (NACK_PERIOD != 0) && (ncnt_q == NW'(NP1));

  // Load extraction: offset aligned down to the access size, oversize means full word.
  always_comb begin
    sz        = (int'(typ_q[1:0]) > OB) ? OB : int'(typ_q[1:0]);
    nbits     = 8 << sz;
    lane_mask = OB'((1 << sz) - 1);
    off_al    = off_q & ~lane_mask;
    shifted   = mem_q[idx_q] >> {off_al, 3'b000};
    load_val  = '0;
    for (int i = 0; i < NUM_DATA_BITS; i++) begin
      if (i < nbits) load_val[i] = shifted[i];
      else           load_val[i] = typ_q[2] ? 1'b0 : shifted[nbits-1];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    tag_d   = tag_q;
    typ_d   = typ_q;
    store_d = store_q;
    nack_d  = nack_q;
    mask_d  = mask_q;
    lat_d   = lat_q;
    ncnt_d  = ncnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        idx_d   = req_addr_i[OB+MEM_DEPTH_LOG2-1:OB];
        off_d   = req_addr_i[OB-1:0];
        tag_d   = req_tag_i;
        typ_d   = req_typ_i;
        store_d = (req_cmd_i == 5'd1);
        mask_d  = req_data_mask_i;
        nack_d  = is_nack;
        ncnt_d  = is_nack ? '0 : ncnt_q + 1'b1;
        state_d = CAPT;
      end
      CAPT: if (req_kill_i) begin
        state_d = IDLE;
      end else begin
        rdata_d = (store_q || nack_q) ? '0 : load_val;
        lat_d   = LW'(RSP_LATENCY - 2);
        state_d = WAIT;
      end
      WAIT: if (lat_q == '0) state_d = RESP;
            else             lat_d   = lat_q - 1'b1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      tag_q   <= '0;
      typ_q   <= '0;
      store_q <= 1'b0;
      nack_q  <= 1'b0;
      mask_q  <= '0;
      lat_q   <= '0;
      ncnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      tag_q   <= tag_d;
      typ_q   <= typ_d;
      store_q <= store_d;
      nack_q  <= nack_d;
      mask_q  <= mask_d;
      lat_q   <= lat_d;
      ncnt_q  <= ncnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; store data is lane-aligned, so the offset plays no part.
  assign wr_en = (state_q == CAPT) && !req_kill_i && store_q && !nack_q && !reset_i;

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (mask_q[i]) mem_q[idx_q][i*8 +: 8] <= req_data_i[i*8 +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign rsp_valid_o = (state_q == RESP) && !nack_q;
  assign rsp_nack_o  = (state_q == RESP) && nack_q;
  assign rsp_tag_o   = (state_q == RESP) ? tag_q : '0;
  assign rsp_typ_o   = (state_q == RESP) ? typ_q : '0;
  assign rsp_data_o  = (state_q == RESP) ? rdata_q : '0;
endmodule
